// File: rtl/rc_encoder.sv
// rc_encoder
// ----------
// Expands each accepted input beat of NI unsigned WS-bit values into a window
// of 2^WS spike beats. Within a window, lane i spikes on exactly u_i beats:
// a lane fires on a beat when its value is strictly greater than the beat's
// key. The key is either the raw phase ("lin", spikes front-loaded) or the
// bit-reversed phase ("rev", spikes spread evenly over the window).
//
// Handshake: on both sides a beat transfers on a rising edge where valid and
// ready are both high. A valid spike beat holds its data/last stable until
// it is accepted. The producer never withdraws valid once asserted.
//
// Ports
//   iCLK                 clock, rising edge
//   iRST                 asynchronous active-high reset
//   iValid_AS_RcIn       input beat valid
//   oReady_AS_RcIn       input beat ready
//   iData_AS_RcIn        NI x WS input values, lane i at [i*WS +: WS]
//   oValid_BM_EnRcSpike  spike beat valid
//   iReady_BM_EnRcSpike  downstream ready for spike beat
//   oData_BM_EnRcSpike   NI spike bits, bit i = lane i
//   oLast_BM_EnRcSpike   high on the final beat (phase W-1) of a window
module rc_encoder #(
  parameter int    NI    = 4,
  parameter int    WS    = 8,
  parameter string ORDER = "rev",
  parameter string BURST = "yes"
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_AS_RcIn,
  output logic             oReady_AS_RcIn,
  input  logic [NI*WS-1:0] iData_AS_RcIn,
  output logic             oValid_BM_EnRcSpike,
  input  logic             iReady_BM_EnRcSpike,
  output logic [NI-1:0]    oData_BM_EnRcSpike,
  output logic             oLast_BM_EnRcSpike
);

  localparam bit          USE_REV   = (ORDER == "rev");
  localparam bit          BURST_EN  = (BURST == "yes");
  localparam logic [WS-1:0] PH_LAST = {WS{1'b1}};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [NI*WS-1:0]  data_q, data_d;
  logic [WS-1:0]     phase_q, phase_d;
  logic [WS-1:0]     key;
  logic              is_last;
  logic              ready_raw;

  function automatic logic [WS-1:0] bitrev(input logic [WS-1:0] x);
    logic [WS-1:0] r;
    for (int k = 0; k < WS; k++) begin
      r[k] = x[WS-1-k];
    end
    return r;
  endfunction

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      data_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      phase_q <= phase_d;
    end
  end

  assign key     = USE_REV ? bitrev(phase_q) : phase_q;
  assign is_last = (phase_q == PH_LAST);

  // Next-state and input-side ready. In BURST mode the input side is opened
  // only on the accepted last beat, so a new window starts with no bubble.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    phase_d   = phase_q;
    ready_raw = 1'b0;
    case (state_q)
      IDLE: begin
        ready_raw = 1'b1;
        if (iValid_AS_RcIn) begin
          data_d  = iData_AS_RcIn;
          phase_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (iReady_BM_EnRcSpike) begin
          if (!is_last) begin
            phase_d = phase_q + WS'(1);
          end else begin
            phase_d = '0;
            if (BURST_EN) begin
              ready_raw = 1'b1;
              if (iValid_AS_RcIn) begin
                data_d = iData_AS_RcIn;
              end else begin
                state_d = IDLE;
              end
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ready is forced low while reset is held, even though the state already
  // reads IDLE asynchronously.
  assign oReady_AS_RcIn = ready_raw & ~iRST;

  // Spike outputs are decoded from registers only.
  always_comb begin
    oValid_BM_EnRcSpike = (state_q == RUN);
    oLast_BM_EnRcSpike  = (state_q == RUN) && is_last;
    oData_BM_EnRcSpike  = '0;
    for (int i = 0; i < NI; i++) begin
      oData_BM_EnRcSpike[i] = (state_q == RUN) && (data_q[i*WS +: WS] > key);
    end
  end

endmodule

// File: tb/tb_rc_encoder.sv
// Directed bench for rc_encoder. Three instances with NI=2, WS=3 (W=8):
//   a: ORDER "lin", BURST "yes"   (shares inputs with b)
//   b: ORDER "rev", BURST "yes"
//   c: ORDER "rev", BURST "no"    (own valid/ready/data)
// Inputs change #1 after the rising edge; outputs are sampled on the
// falling edge.
module tb_rc_encoder;

  logic       clk;
  logic       rst;

  logic       v_ab, r_ab;
  logic [5:0] d_ab;
  logic       v_c, r_c;
  logic [5:0] d_c;

  logic       ready_a, valid_a, last_a;
  logic [1:0] data_a;
  logic       ready_b, valid_b, last_b;
  logic [1:0] data_b;
  logic       ready_c, valid_c, last_c;
  logic [1:0] data_c;

  int checks;
  int failures;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  rc_encoder #(.NI(2), .WS(3), .ORDER("lin"), .BURST("yes")) u_a (
    .iCLK(clk), .iRST(rst),
    .iValid_AS_RcIn(v_ab), .oReady_AS_RcIn(ready_a), .iData_AS_RcIn(d_ab),
    .oValid_BM_EnRcSpike(valid_a), .iReady_BM_EnRcSpike(r_ab),
    .oData_BM_EnRcSpike(data_a), .oLast_BM_EnRcSpike(last_a)
  );

  rc_encoder #(.NI(2), .WS(3), .ORDER("rev"), .BURST("yes")) u_b (
    .iCLK(clk), .iRST(rst),
    .iValid_AS_RcIn(v_ab), .oReady_AS_RcIn(ready_b), .iData_AS_RcIn(d_ab),
    .oValid_BM_EnRcSpike(valid_b), .iReady_BM_EnRcSpike(r_ab),
    .oData_BM_EnRcSpike(data_b), .oLast_BM_EnRcSpike(last_b)
  );

  rc_encoder #(.NI(2), .WS(3), .ORDER("rev"), .BURST("no")) u_c (
    .iCLK(clk), .iRST(rst),
    .iValid_AS_RcIn(v_c), .oReady_AS_RcIn(ready_c), .iData_AS_RcIn(d_c),
    .oValid_BM_EnRcSpike(valid_c), .iReady_BM_EnRcSpike(r_c),
    .oData_BM_EnRcSpike(data_c), .oLast_BM_EnRcSpike(last_c)
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // One full window on a/b with iReady held high. m* are expected spike
  // masks (bit p = phase p). If chain is set, the next input is offered
  // during the last beat.
  task automatic win_ab(input logic [7:0] ma0, input logic [7:0] ma1,
                        input logic [7:0] mb0, input logic [7:0] mb1,
                        input int u0, input int u1,
                        input bit chain, input logic [5:0] nd);
    int c0;
    int c1;
    c0 = 0;
    c1 = 0;
    r_ab = 1'b1;
    for (int p = 0; p < 8; p++) begin
      if (p == 7 && chain) begin
        v_ab = 1'b1;
        d_ab = nd;
      end else begin
        v_ab = 1'b0;
      end
      @(negedge clk);
      chk("a_valid", 32'(valid_a), 32'd1);
      chk("a_data",  32'(data_a),  32'({ma1[p], ma0[p]}));
      chk("a_last",  32'(last_a),  32'(p == 7));
      chk("a_ready", 32'(ready_a), 32'(p == 7));
      chk("b_valid", 32'(valid_b), 32'd1);
      chk("b_data",  32'(data_b),  32'({mb1[p], mb0[p]}));
      chk("b_last",  32'(last_b),  32'(p == 7));
      chk("b_ready", 32'(ready_b), 32'(p == 7));
      c0 += int'(data_b[0]);
      c1 += int'(data_b[1]);
      step();
    end
    v_ab = 1'b0;
    chk("b_pop0", 32'(c0), 32'(u0));
    chk("b_pop1", 32'(c1), 32'(u1));
  endtask

  // One full window on c (non-burst): ready must stay low through RUN.
  task automatic win_c(input logic [7:0] m0, input logic [7:0] m1,
                       input bit chain, input logic [5:0] nd);
    r_c = 1'b1;
    for (int p = 0; p < 8; p++) begin
      if (p == 7 && chain) begin
        v_c = 1'b1;
        d_c = nd;
      end else begin
        v_c = 1'b0;
      end
      @(negedge clk);
      chk("c_valid", 32'(valid_c), 32'd1);
      chk("c_data",  32'(data_c),  32'({m1[p], m0[p]}));
      chk("c_last",  32'(last_c),  32'(p == 7));
      chk("c_ready", 32'(ready_c), 32'd0);
      step();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0] pd;
    logic       pl;
    bit         pstall;
    bit         done;
    int         acc0, acc1, lasts, n;

    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    v_ab = 1'b1; r_ab = 1'b1; d_ab = 6'h3f;
    v_c  = 1'b1; r_c  = 1'b1; d_c  = 6'h3f;

    // Reset held 3 cycles with valid high: nothing accepted, nothing out.
    repeat (3) begin
      @(negedge clk);
      chk("rst_a_valid", 32'(valid_a), 32'd0);
      chk("rst_a_ready", 32'(ready_a), 32'd0);
      chk("rst_a_data",  32'(data_a),  32'd0);
      chk("rst_a_last",  32'(last_a),  32'd0);
      chk("rst_c_valid", 32'(valid_c), 32'd0);
      chk("rst_c_ready", 32'(ready_c), 32'd0);
    end
    step();
    rst  = 1'b0;
    v_ab = 1'b0;
    v_c  = 1'b0;
    @(negedge clk);
    chk("rel_a_ready", 32'(ready_a), 32'd1);
    chk("rel_c_ready", 32'(ready_c), 32'd1);
    chk("rel_a_valid", 32'(valid_a), 32'd0);
    step();
    @(negedge clk);
    chk("rel_b_valid", 32'(valid_b), 32'd0);
    step();

    // Single window u=(lane0=3, lane1=0).
    // lin lane0: phases 0,1,2. rev lane0: phases 0,2,4.
    v_ab = 1'b1;
    d_ab = {3'd0, 3'd3};
    @(negedge clk);
    chk("acc1_ready", 32'(ready_a), 32'd1);
    step();
    win_ab(8'b0000_0111, 8'h00, 8'b0001_0101, 8'h00, 3, 0, 1'b0, 6'd0);
    @(negedge clk);
    chk("end1_a_valid", 32'(valid_a), 32'd0);
    chk("end1_a_ready", 32'(ready_a), 32'd1);
    step();

    // Burst: (3,0) then (7,5) back to back; 16 consecutive beats.
    // lin 7: 0111_1111, lin 5: 0001_1111; rev 7: 0111_1111, rev 5: 0101_0111.
    v_ab = 1'b1;
    d_ab = {3'd0, 3'd3};
    step();
    win_ab(8'b0000_0111, 8'h00, 8'b0001_0101, 8'h00, 3, 0, 1'b1, {3'd5, 3'd7});
    win_ab(8'b0111_1111, 8'b0001_1111, 8'b0111_1111, 8'b0101_0111, 7, 5, 1'b0, 6'd0);
    @(negedge clk);
    chk("end2_b_valid", 32'(valid_b), 32'd0);
    step();

    // Same stimulus on the non-burst instance: one idle cycle between windows.
    v_c = 1'b1;
    d_c = {3'd0, 3'd3};
    @(negedge clk);
    chk("c_acc_ready", 32'(ready_c), 32'd1);
    step();
    win_c(8'b0001_0101, 8'h00, 1'b1, {3'd5, 3'd7});
    @(negedge clk);
    chk("c_gap_valid", 32'(valid_c), 32'd0);
    chk("c_gap_ready", 32'(ready_c), 32'd1);
    step();
    v_c = 1'b0;
    win_c(8'b0111_1111, 8'b0101_0111, 1'b0, 6'd0);
    @(negedge clk);
    chk("c_end_valid", 32'(valid_c), 32'd0);
    step();

    // Backpressure on b with random ready: u=(5,1).
    v_ab = 1'b1;
    d_ab = {3'd1, 3'd5};
    step();
    v_ab   = 1'b0;
    pstall = 1'b0;
    done   = 1'b0;
    pd     = '0;
    pl     = 1'b0;
    acc0 = 0; acc1 = 0; lasts = 0; n = 0;
    while (!done && n < 200) begin
      r_ab = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (pstall) begin
        chk("bp_data_hold", 32'(data_b), 32'(pd));
        chk("bp_last_hold", 32'(last_b), 32'(pl));
      end
      if (last_b && !r_ab) begin
        chk("bp_ready_stall", 32'(ready_b), 32'd0);
      end
      if (valid_b && r_ab) begin
        acc0 += int'(data_b[0]);
        acc1 += int'(data_b[1]);
        if (last_b) begin
          lasts++;
          done = 1'b1;
        end
      end
      pstall = valid_b && !r_ab;
      pd     = data_b;
      pl     = last_b;
      step();
      n++;
    end
    r_ab = 1'b1;
    chk("bp_finished", 32'(done), 32'd1);
    chk("bp_pop0", 32'(acc0), 32'd5);
    chk("bp_pop1", 32'(acc1), 32'd1);
    chk("bp_lasts", 32'(lasts), 32'd1);
    @(negedge clk);
    chk("bp_end_valid", 32'(valid_b), 32'd0);
    step();

    // Mid-window reset at phase 4, then a fresh window for u=(5,1).
    v_ab = 1'b1;
    d_ab = {3'd2, 3'd6};
    step();
    v_ab = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("mid_a_data_p4", 32'(data_a), 32'b01);
    chk("mid_a_last_p4", 32'(last_a), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_a_valid", 32'(valid_a), 32'd0);
    chk("mid_b_valid", 32'(valid_b), 32'd0);
    chk("mid_a_data",  32'(data_a),  32'd0);
    chk("mid_a_ready", 32'(ready_a), 32'd0);
    step();
    step();
    rst  = 1'b0;
    v_ab = 1'b1;
    d_ab = {3'd1, 3'd5};
    @(negedge clk);
    chk("mid_rel_ready", 32'(ready_a), 32'd1);
    step();
    win_ab(8'b0001_1111, 8'b0000_0001, 8'b0101_0111, 8'b0000_0001, 5, 1, 1'b0, 6'd0);
    @(negedge clk);
    chk("mid_end_valid", 32'(valid_a), 32'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rc_encoder.md
# rc_encoder

Converts a stream of unsigned reservoir input words into rate-coded spike windows for the hybrid reservoir core, forming the inverse of the RC accumulate/decode path. Each accepted input beat carries NI values of WS bits. Each value u is expanded into a window of 2^WS output beats in which lane i spikes exactly u_i times. The block sits between the host-side input register and the reservoir's spike input and uses the same valid/ready stream handshake on both sides.

## Interface
- NI, 4: number of input lanes (reservoir inputs).
- WS, 8: value/phase width; window length W = 2^WS beats.
- ORDER, "rev": spike placement. "rev" spreads spikes evenly using the bit-reversed phase. "lin" front-loads spikes from phase 0.
- BURST, "yes": "yes" allows back-to-back windows with no bubble. "no" inserts one idle cycle between windows.
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST  in  1  reset; asynchronous, active-high.
- iValid_AS_RcIn  in  1  input beat valid.
- oReady_AS_RcIn  out  1  input beat accepted when high together with valid.
- iData_AS_RcIn  in  NI*WS  lane i value at bits [i*WS +: WS], unsigned.
- oValid_BM_EnRcSpike  out  1  spike beat valid.
- iReady_BM_EnRcSpike  in  1  downstream accepts spike beat.
- oData_BM_EnRcSpike  out  NI  spike vector; bit i belongs to lane i.
- oLast_BM_EnRcSpike  out  1  marks beat W-1 of the current window.

## Operation
- Registers:
  - data_r (NI*WS)
  - phase_r (WS)
  - state ∈ {IDLE, RUN}
- IDLE:
  - oReady_AS=1, oValid_BM=0.
  - On iValid&oReady: latch data_r, set phase_r=0, move to RUN.
- RUN:
  - oValid_BM=1.
  - oData_BM[i] = (data_r[i] > key), where key = bitrev(phase_r) for ORDER "rev", or phase_r for "lin". Comparison is unsigned on WS bits.
  - oLast_BM = (phase_r == W-1).
  - On iReady_BM with phase_r < W-1: increment phase_r.
  - On iReady_BM with phase_r == W-1 (last beat accepted):
    - BURST "yes": oReady_AS=1 during this last beat. If iValid_AS is also high, load the new data, set phase_r=0 and stay in RUN. Otherwise go to IDLE.
    - BURST "no": oReady_AS=0 throughout RUN; go to IDLE.
- oReady_AS in RUN with BURST "yes" equals (phase_r==W-1) & iReady_BM. This is a combinational path from iReady_BM, which is allowed.
- Spike count per lane per window is exactly u_i: u=0 gives no spikes; u=W-1 gives W-1 spikes. No lane ever spikes at all W phases.
- No combinational path from iData_AS or iValid_AS to any output. oData_BM and oLast_BM are decoded from registers only.
- phase_r wraps from W-1 to 0 only on a window boundary. It never advances without iReady_BM.

## Timing
- Reset (iRST high, asynchronous): state=IDLE, phase_r=0, data_r=0. Outputs: oValid_BM=0, oData_BM=0, oLast_BM=0, oReady_AS=0 while iRST is held. After release, oReady_AS=1 from the first IDLE cycle.
- Latency: input accepted at edge t; first spike beat is valid in the cycle after t.
- Window duration: W cycles with no backpressure.
- Throughput with no backpressure:
  - BURST "yes": one input per W cycles.
  - BURST "no": one input per W+1 cycles.
- Backpressure: while oValid_BM & !iReady_BM, oData_BM, oLast_BM and phase_r hold stable. oReady_AS stays 0 in RUN, including on the last beat.
- Reset asserted mid-window: the window is abandoned immediately and oValid_BM drops asynchronously. No partial-window resume after release.
- Simultaneous last-beat accept and new-input accept (BURST "yes"): the new window's phase 0 appears in the next cycle with no gap.

## Test plan
- Reset: hold iRST high 3 cycles with iValid_AS=1 -> oValid_BM=0, oReady_AS=0, no beat accepted. Release -> oReady_AS=1 next cycle.
- Linear placement (NI=2, WS=3, ORDER "lin"): input u=(3,0) -> 8 beats; lane0 high at phases 0,1,2; lane1 always 0; oLast on beat 7 only.
- Bit-reversed placement (ORDER "rev"): input u0=3 -> lane0 high at phases 0,2,4 only. Input u0=7 -> high on every phase except 7. Per-window popcount equals u in both cases.
- Burst (BURST "yes"): two inputs back-to-back, iReady_BM=1 -> 16 consecutive valid beats with no gap; second input accepted on the cycle of the first window's beat 7. Same stimulus with BURST "no" -> one idle cycle between the windows.
- Backpressure: random iReady_BM at 50% -> oData_BM and oLast_BM stable while stalled; per-lane accepted spike count equals u; exactly one accepted oLast per window.
- Mid-window reset: assert iRST at phase 4 -> oValid_BM=0 immediately. After release, a new input u=(5,1) produces a fresh full window starting at phase 0.
